qcw_shot_sequencer: RTL and testbench

Sequences single QCW shots of the bridge driver. On each accepted trigger it issues the driver start handshake, ramps the phase-shift command linearly, once per RF cycle, from a start to an end value, and sets the cycle limit. It enforces a minimum off-time between shots, supervises the driver with timeouts, and latches faults. It sits between the host/interrupter logic and the bridge driver.

---
 rtl/qcw_shot_sequencer.sv | 132 +++++++++++++
 tb/tb_qcw_shot_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/qcw_shot_sequencer.sv
// qcw_shot_sequencer: issues one QCW shot per accepted trigger, ramps the phase command per RF cycle,
// enforces inter-shot off-time and supervises the bridge driver with accept and cycle watchdogs.
module qcw_shot_sequencer #(
  parameter int PHASE_MIN      = 50,
  parameter int PHASE_MAX      = 254,
  parameter int MIN_HOLDOFF    = 100000,
  parameter int ACCEPT_TIMEOUT = 64,
  parameter int WDT_CLKS       = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trigger,
  input  logic        abort,
  input  logic        fault_clear,
  input  logic [7:0]  cfg_start_phase,
  input  logic [7:0]  cfg_end_phase,
  input  logic [15:0] cfg_step,
  input  logic [15:0] cfg_cycles,
  input  logic [23:0] cfg_holdoff,
  input  logic        drv_ready,
  input  logic        drv_cycle_finished,
  output logic        drv_start,
  output logic        drv_halt,
  output logic [7:0]  drv_phase_shift,
  output logic [15:0] drv_cycle_limit,
  output logic        busy,
  output logic        shot_done,
  output logic        trig_dropped,
  output logic        fault,
  output logic [1:0]  fault_code
);
  typedef enum logic [2:0] {IDLE, ARM, WAIT_ACCEPT, RUN, HOLDOFF, FAULT} state_t;
  localparam logic [23:0] HOLD_MIN = 24'(MIN_HOLDOFF);
  localparam logic [23:0] ACC_LAST = 24'(ACCEPT_TIMEOUT - 1);
  localparam logic [23:0] WDT_LAST = 24'(WDT_CLKS - 1);
  localparam logic [7:0]  P_MIN    = 8'(PHASE_MIN);
  localparam logic [7:0]  P_MAX    = 8'(PHASE_MAX);
  state_t state, state_n;
  logic [23:0] cnt, cnt_n, hold_r;
  logic [15:0] acc, acc_n, step_r, acc_sat;
  logic [16:0] sum;
  logic [7:0]  end_r, top, phase_n;
  logic [1:0]  code_n;
  logic        halt_n;
  assign sum     = {1'b0, acc} + {1'b0, step_r};
  assign acc_sat = (sum >= {1'b0, end_r, 8'h00}) ? {end_r, 8'h00} : sum[15:0];
  assign top     = acc_n[15:8];
  assign phase_n = top < P_MIN ? P_MIN : top > P_MAX ? P_MAX : top;
  assign halt_n  = (state == FAULT) ? drv_halt && !drv_ready : state_n == FAULT;
  assign drv_start    = state == ARM;
  assign busy         = state != IDLE;
  assign fault        = state == FAULT;
  assign trig_dropped = trigger && state != IDLE;
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    acc_n   = acc;
    code_n  = fault_code;
    case (state)
      IDLE: if (trigger && drv_ready) begin
        state_n = ARM;
        acc_n   = {cfg_start_phase, 8'h00};
      end
      ARM: begin
        state_n = abort ? FAULT : WAIT_ACCEPT;
        code_n  = abort ? 2'd3 : fault_code;
        cnt_n   = '0;
      end
      WAIT_ACCEPT: if (abort) begin
        state_n = FAULT;
        code_n  = 2'd3;
      end else if (!drv_ready) begin
        state_n = RUN;
        cnt_n   = '0;
      end else if (cnt == ACC_LAST) begin
        state_n = FAULT;
        code_n  = 2'd1;
      end else cnt_n = cnt + 24'd1;
      RUN: if (abort) begin
        state_n = FAULT;
        code_n  = 2'd3;
      end else if (drv_ready) begin
        state_n = HOLDOFF;
        cnt_n   = hold_r;
      end else if (drv_cycle_finished) begin
        cnt_n   = '0;
        acc_n   = acc_sat;
      end else if (cnt == WDT_LAST) begin
        state_n = FAULT;
        code_n  = 2'd2;
      end else cnt_n = cnt + 24'd1;
      HOLDOFF: if (cnt <= 24'd1) state_n = IDLE;
      else cnt_n = cnt - 24'd1;
      FAULT: if (fault_clear && drv_ready) begin
        state_n = HOLDOFF;
        code_n  = 2'd0;
        cnt_n   = HOLD_MIN;
      end
      default: state_n = IDLE;
    endcase
  end
  // A reversed ramp saturates at its own start, so the phase holds for the whole shot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      acc             <= '0;
      end_r           <= '0;
      step_r          <= '0;
      hold_r          <= '0;
      drv_cycle_limit <= '0;
      drv_phase_shift <= P_MIN;
      drv_halt        <= 1'b0;
      shot_done       <= 1'b0;
      fault_code      <= 2'd0;
    end else begin
      state           <= state_n;
      cnt             <= cnt_n;
      acc             <= acc_n;
      drv_phase_shift <= phase_n;
      drv_halt        <= halt_n;
      shot_done       <= state == RUN && state_n == HOLDOFF;
      fault_code      <= code_n;
      if (state == IDLE && state_n == ARM) begin
        end_r           <= cfg_end_phase < cfg_start_phase ? cfg_start_phase : cfg_end_phase;
        step_r          <= cfg_step;
        hold_r          <= cfg_holdoff > HOLD_MIN ? cfg_holdoff : HOLD_MIN;
        drv_cycle_limit <= cfg_cycles;
      end
    end
  end
endmodule

// File: tb/tb_qcw_shot_sequencer.sv
// tb_qcw_shot_sequencer: directed shots against hand-computed phase ramps, timeouts and holdoff timing.
module tb_qcw_shot_sequencer;
  localparam int HO = 300;
  logic        clk = 1'b0, rst = 1'b1;
  logic        trigger = 0, abort = 0, fault_clear = 0;
  logic [7:0]  cfg_start_phase = 0, cfg_end_phase = 0;
  logic [15:0] cfg_step = 0, cfg_cycles = 0;
  logic [23:0] cfg_holdoff = 0;
  logic        drv_ready = 1, drv_cycle_finished = 0;
  logic        drv_start, drv_halt, busy, shot_done, trig_dropped, fault;
  logic [7:0]  drv_phase_shift;
  logic [15:0] drv_cycle_limit;
  logic [1:0]  fault_code;
  int checks = 0, errors = 0, starts = 0;

  qcw_shot_sequencer #(.MIN_HOLDOFF(HO)) dut (
    .clk(clk), .rst(rst), .trigger(trigger), .abort(abort), .fault_clear(fault_clear),
    .cfg_start_phase(cfg_start_phase), .cfg_end_phase(cfg_end_phase), .cfg_step(cfg_step),
    .cfg_cycles(cfg_cycles), .cfg_holdoff(cfg_holdoff), .drv_ready(drv_ready),
    .drv_cycle_finished(drv_cycle_finished), .drv_start(drv_start), .drv_halt(drv_halt),
    .drv_phase_shift(drv_phase_shift), .drv_cycle_limit(drv_cycle_limit), .busy(busy),
    .shot_done(shot_done), .trig_dropped(trig_dropped), .fault(fault), .fault_code(fault_code));

  always #5 clk = ~clk;
  always @(negedge clk) if (drv_start) starts++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    drv_cycle_finished = 1;
    tick();
    drv_cycle_finished = 0;
  endtask

  task automatic start_shot(input logic [7:0] s, input logic [7:0] e, input logic [15:0] st,
                            input logic [15:0] cy);
    cfg_start_phase = s; cfg_end_phase = e; cfg_step = st; cfg_cycles = cy; cfg_holdoff = 0;
    drv_ready = 1; trigger = 1;
    tick();
    trigger = 0;
    chk("arm_start", drv_start, 1);
    tick();
    drv_ready = 0;
    tick();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2 * HO) begin
      tick();
      n++;
    end
    chk("idle_reached", busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [7:0] clamp_exp [4];
    clamp_exp = '{8'd94, 8'd158, 8'd222, 8'd254};
    tick(); tick();
    chk("rst_phase", drv_phase_shift, 50);
    chk("rst_busy", busy, 0);
    chk("rst_code", fault_code, 0);
    chk("rst_limit", drv_cycle_limit, 0);
    #2 rst = 0;
    drv_ready = 0; trigger = 1;
    tick();
    chk("notready_busy", busy, 0);
    chk("notready_drop", trig_dropped, 0);
    trigger = 0; abort = 1;
    tick();
    chk("idle_abort_fault", fault, 0);
    abort = 0;

    // nominal ramp, with cfg scrambled after the latch
    cfg_start_phase = 60; cfg_end_phase = 200; cfg_step = 16'h0A00; cfg_cycles = 20;
    cfg_holdoff = 0; drv_ready = 1; trigger = 1;
    tick();
    trigger = 0;
    chk("nom_start", drv_start, 1);
    chk("nom_limit", drv_cycle_limit, 20);
    chk("nom_phase0", drv_phase_shift, 60);
    cfg_start_phase = 0; cfg_end_phase = 0; cfg_step = 16'hFFFF; cfg_cycles = 5;
    tick();
    chk("nom_start_once", drv_start, 0);
    drv_ready = 0;
    tick();
    for (int i = 1; i <= 20; i++) begin
      repeat (599) tick();
      pulse();
      chk($sformatf("nom_phase%0d", i), drv_phase_shift, (60 + 10 * i > 200) ? 200 : 60 + 10 * i);
    end
    drv_ready = 1;
    tick();
    chk("nom_done", shot_done, 1);
    tick();
    chk("nom_done_pulse", shot_done, 0);
    repeat (HO - 2) tick();
    chk("nom_holdoff_busy", busy, 1);
    tick();
    chk("nom_holdoff_end", busy, 0);
    chk("nom_starts", starts, 1);
    chk("nom_limit_hold", drv_cycle_limit, 20);

    // clamp at both ends
    start_shot(8'd30, 8'd255, 16'h4000, 16'd8);
    chk("clamp_low", drv_phase_shift, 50);
    for (int k = 0; k < 4; k++) begin
      repeat (10) tick();
      pulse();
      chk($sformatf("clamp%0d", k), drv_phase_shift, clamp_exp[k]);
    end
    drv_ready = 1;
    tick();
    wait_idle();

    // reversed ramp holds start
    start_shot(8'd200, 8'd100, 16'h1000, 16'd8);
    for (int k = 0; k < 3; k++) begin
      repeat (5) tick();
      pulse();
      chk($sformatf("rev%0d", k), drv_phase_shift, 200);
    end
    drv_ready = 1;
    tick();
    wait_idle();

    // accept timeout
    drv_ready = 1; trigger = 1;
    tick();
    trigger = 0;
    repeat (64) tick();
    chk("acc_before", fault, 0);
    tick();
    chk("acc_fault", fault, 1);
    chk("acc_code", fault_code, 1);
    chk("acc_halt", drv_halt, 1);
    drv_ready = 0; fault_clear = 1;
    tick();
    chk("acc_halt_hold", drv_halt, 1);
    chk("acc_clear_ignored", fault, 1);
    fault_clear = 0; drv_ready = 1;
    tick();
    chk("acc_halt_drop", drv_halt, 0);
    fault_clear = 1;
    tick();
    fault_clear = 0;
    chk("acc_cleared", fault, 0);
    chk("acc_code_clr", fault_code, 0);
    repeat (HO - 1) tick();
    chk("acc_hold_busy", busy, 1);
    tick();
    chk("acc_hold_end", busy, 0);

    // watchdog
    start_shot(8'd60, 8'd200, 16'h0100, 16'd100);
    repeat (5) tick();
    pulse();
    repeat (4095) tick();
    chk("wdt_before", drv_halt, 0);
    tick();
    chk("wdt_halt", drv_halt, 1);
    chk("wdt_code", fault_code, 2);
    tick();
    chk("wdt_halt_hold", drv_halt, 1);
    drv_ready = 1;
    tick();
    chk("wdt_halt_drop", drv_halt, 0);
    fault_clear = 1;
    tick();
    fault_clear = 0;
    wait_idle();

    // abort collides with completion
    start_shot(8'd60, 8'd200, 16'h0100, 16'd10);
    abort = 1; drv_ready = 1;
    tick();
    abort = 0;
    chk("abort_code", fault_code, 3);
    chk("abort_no_done", shot_done, 0);
    chk("abort_halt", drv_halt, 1);
    fault_clear = 1;
    tick();
    fault_clear = 0;
    abort = 1;
    tick();
    abort = 0;
    chk("holdoff_abort_ignored", fault, 0);
    wait_idle();

    // retrigger held high
    cfg_start_phase = 100; cfg_end_phase = 200; cfg_step = 16'h0100; cfg_cycles = 7;
    drv_ready = 1; trigger = 1;
    tick();
    chk("rt_arm_drop", trig_dropped, 1);
    tick();
    chk("rt_wait_drop", trig_dropped, 1);
    drv_ready = 0;
    tick();
    chk("rt_run_drop", trig_dropped, 1);
    drv_ready = 1;
    begin
      int misses = 0, n = 0;
      tick();
      while (busy && n < 2 * HO) begin
        if (!trig_dropped) misses++;
        tick();
        n++;
      end
      chk("rt_hold_drops", misses, 0);
      chk("rt_hold_len", n, HO);
    end
    chk("rt_idle_nodrop", trig_dropped, 0);
    tick();
    chk("rt_restart", drv_start, 1);
    trigger = 0;
    tick();
    drv_ready = 0;
    tick();
    pulse();
    chk("rt_phase", drv_phase_shift, 101);
    rst = 1;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_phase", drv_phase_shift, 50);
    chk("rst_mid_start", drv_start, 0);
    chk("rst_mid_limit", drv_cycle_limit, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
